// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: multiplexed scanner for a common-anode 7-seg display.
// Tear-free shadow value, guard-banded slots, leading-zero suppression.
module sseg_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [3:0]              hex_out,
  output logic                    blank_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD =
    CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0][3:0] pend;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [NUM_DIGITS-1:0]      pend_dp;
  logic                       pend_vld;

  logic                       slot_end;
  logic                       wrap;
  logic [NUM_DIGITS-1:0]      supp;
  logic                       zero_run;
  logic                       blank_nx;
  logic [NUM_DIGITS-1:0]      an_nx;
  logic                       dp_nx;
  logic [3:0]                 hex_nx;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  // Slot counter and digit index; idx advances on the last slot cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending capture; the last load inside a frame wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      pend_dp <= '0;
    end else if (load && !wrap) begin
      pend    <= data_in;
      pend_dp <= dp_in;
    end
  end

  // Pending flag: set by a mid-frame load, cleared at every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
    end else if (wrap) begin
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_vld <= 1'b1;
    end
  end

  // Shadow only moves at frame wrap; a wrap-cycle load bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
    end else if (wrap && load) begin
      shadow    <= data_in;
      shadow_dp <= dp_in;
    end else if (wrap && pend_vld) begin
      shadow    <= pend;
      shadow_dp <= pend_dp;
    end
  end

  // Digit k is a leading zero when it and every higher nibble are zero.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow[k] == 4'h0);
      supp[k]  = lz_blank && zero_run;
    end
  end

  // Next-cycle view of the active slot.
  always_comb begin
    hex_nx   = shadow[idx];
    blank_nx = (cnt < CNT_GUARD)
             || !digit_en[idx]
             || supp[idx];
    an_nx    = '1;
    if (!blank_nx) begin
      an_nx = ~(NUM_DIGITS'(1) << idx);
    end
    dp_nx    = blank_nx || !shadow_dp[idx];
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out    <= 4'h0;
      blank_out  <= 1'b1;
      an         <= '1;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      hex_out    <= hex_nx;
      blank_out  <= blank_nx;
      an         <= an_nx;
      dp_out     <= dp_nx;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: randomized and directed checks of sseg_scan_mux.
// Reference is a time-indexed model of the display rules.
module tb_sseg_scan_mux;

  localparam int N = 8;
  localparam int R = 8;
  localparam int G = 2;
  localparam int F = R * N;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        load;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  hex_out;
  logic        blank_out;
  logic [7:0]  an;
  logic        dp_out;
  logic        frame_tick;

  int checks;
  int failures;

  sseg_scan_mux #(
    .NUM_DIGITS(N),
    .REFRESH_DIV(R),
    .GUARD(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .dp_in(dp_in),
    .load(load),
    .digit_en(digit_en),
    .lz_blank(lz_blank),
    .hex_out(hex_out),
    .blank_out(blank_out),
    .an(an),
    .dp_out(dp_out),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: m_t counts cycles since reset release.
  int          m_t;
  logic [31:0] m_sh;
  logic [7:0]  m_sdp;
  logic [31:0] m_pd;
  logic [7:0]  m_pdp;
  logic        m_pv;
  logic [7:0]  e_an;
  logic        e_blank;
  logic        e_dp;
  logic [3:0]  e_hex;
  logic        e_tick;

  function automatic int dig_of(int t);
    return (t / R) % N;
  endfunction

  function automatic logic is_wrap(int t);
    return (t % F) == F - 1;
  endfunction

  function automatic logic blanked(int t, logic [31:0] sh,
                                   logic [7:0] en, logic lz);
    int d;
    logic sup;
    d = dig_of(t);
    sup = (d >= 1) && lz && ((sh >> (4 * d)) == 32'h0);
    return ((t % R) < G) || !en[d] || sup;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= 0;
      m_sh    <= '0;
      m_sdp   <= '0;
      m_pd    <= '0;
      m_pdp   <= '0;
      m_pv    <= 1'b0;
      e_an    <= 8'hFF;
      e_blank <= 1'b1;
      e_dp    <= 1'b1;
      e_hex   <= 4'h0;
      e_tick  <= 1'b0;
    end else begin
      e_hex   <= 4'((m_sh >> (4 * dig_of(m_t))) & 32'hF);
      e_blank <= blanked(m_t, m_sh, digit_en, lz_blank);
      e_an    <= blanked(m_t, m_sh, digit_en, lz_blank)
                 ? 8'hFF : ~(8'h01 << dig_of(m_t));
      e_dp    <= blanked(m_t, m_sh, digit_en, lz_blank)
                 || !m_sdp[dig_of(m_t)];
      e_tick  <= is_wrap(m_t);
      m_t     <= m_t + 1;
      if (load) begin
        if (is_wrap(m_t)) begin
          m_sh  <= data_in;
          m_sdp <= dp_in;
          m_pv  <= 1'b0;
        end else begin
          m_pd  <= data_in;
          m_pdp <= dp_in;
          m_pv  <= 1'b1;
        end
      end else if (is_wrap(m_t) && m_pv) begin
        m_sh  <= m_pd;
        m_sdp <= m_pdp;
        m_pv  <= 1'b0;
      end
    end
  end

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (43) @(negedge clk);
    checks++;
    if (an !== 8'hDF) begin
      failures++;
      $display("FAIL reset_prescan an=%h exp=%h", an, 8'hDF);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, blank_out, dp_out, hex_out, frame_tick}
        !== {8'hFF, 1'b1, 1'b1, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async an=%h bl=%b dp=%b hex=%h tk=%b exp FF 1 1 0 0",
               an, blank_out, dp_out, hex_out, frame_tick);
    end
    @(negedge clk);
    checks++;
    if ({an, blank_out, dp_out, hex_out, frame_tick}
        !== {8'hFF, 1'b1, 1'b1, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold an=%h bl=%b dp=%b hex=%h tk=%b exp FF 1 1 0 0",
               an, blank_out, dp_out, hex_out, frame_tick);
    end
    rst_n = 1'b1;
    n = 0;
    while (an !== 8'hFE && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL reset_first_anode cycles=%0d exp=3 an=%h", n, an);
    end
  endtask

  task automatic test_scan;
    int n;
    int lit [8];
    int off;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    data_in  = 32'h1234ABCD;
    dp_in    = 8'h00;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!frame_tick && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_tick) begin
      failures++;
      $display("FAIL scan_tick_timeout tk=%b exp=1", frame_tick);
    end
    foreach (lit[d]) lit[d] = 0;
    off = 0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      checks++;
      if ({an, blank_out, dp_out, hex_out, frame_tick}
          !== {e_an, e_blank, e_dp, e_hex, e_tick}) begin
        failures++;
        $display("FAIL scan_model i=%0d got %h %b %b %h %b exp %h %b %b %h %b",
                 i, an, blank_out, dp_out, hex_out, frame_tick,
                 e_an, e_blank, e_dp, e_hex, e_tick);
      end
      if (an == 8'hFF) off++;
      for (int d = 0; d < N; d++) begin
        if (an == ~(8'h01 << d)) lit[d]++;
      end
      if (an == 8'hFE) begin
        checks++;
        if (hex_out !== 4'hD) begin
          failures++;
          $display("FAIL scan_digit0 hex=%h exp=D", hex_out);
        end
      end
      if (an == 8'h7F) begin
        checks++;
        if (hex_out !== 4'h1) begin
          failures++;
          $display("FAIL scan_digit7 hex=%h exp=1", hex_out);
        end
      end
      checks++;
      if (frame_tick !== (i == F - 1)) begin
        failures++;
        $display("FAIL scan_period i=%0d tk=%b exp=%b",
                 i, frame_tick, i == F - 1);
      end
    end
    for (int d = 0; d < N; d++) begin
      checks++;
      if (lit[d] != R - G) begin
        failures++;
        $display("FAIL scan_lit d=%0d got=%0d exp=%0d", d, lit[d], R - G);
      end
    end
    checks++;
    if (off != N * G) begin
      failures++;
      $display("FAIL scan_guard got=%0d exp=%0d", off, N * G);
    end
  endtask

  task automatic test_tear;
    int n;
    int f;
    logic [3:0] want;
    data_in = 32'h11111111;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!frame_tick && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_tick) begin
      failures++;
      $display("FAIL tear_tick_timeout tk=%b exp=1", frame_tick);
    end
    for (int i = 0; i < 3 * F; i++) begin
      load = 1'b0;
      if (i == 24) begin
        data_in = 32'h22222222;
        load    = 1'b1;
      end
      if (i == F + 10) begin
        data_in = 32'h33333333;
        load    = 1'b1;
      end
      if (i == F + 20) begin
        data_in = 32'h44444444;
        load    = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      f = i / F;
      want = (f == 0) ? 4'h1 : (f == 1) ? 4'h2 : 4'h4;
      checks++;
      if ({an, blank_out, dp_out, hex_out, frame_tick}
          !== {e_an, e_blank, e_dp, e_hex, e_tick}) begin
        failures++;
        $display("FAIL tear_model i=%0d got %h %b %b %h %b exp %h %b %b %h %b",
                 i, an, blank_out, dp_out, hex_out, frame_tick,
                 e_an, e_blank, e_dp, e_hex, e_tick);
      end
      if (an != 8'hFF) begin
        checks++;
        if (hex_out !== want) begin
          failures++;
          $display("FAIL tear_value i=%0d hex=%h exp=%h", i, hex_out, want);
        end
      end
    end
  endtask

  task automatic test_wrap_load;
    for (int i = 0; i < 3 * F; i++) begin
      load = 1'b0;
      if (i == 10) begin
        data_in = 32'h12345678;
        load    = 1'b1;
      end
      if (i == F - 1) begin
        data_in = 32'h0000BEEF;
        load    = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      if (i == F - 1) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          failures++;
          $display("FAIL wrap_align tk=%b exp=1", frame_tick);
        end
      end
      checks++;
      if ({an, blank_out, dp_out, hex_out, frame_tick}
          !== {e_an, e_blank, e_dp, e_hex, e_tick}) begin
        failures++;
        $display("FAIL wrap_model i=%0d got %h %b %b %h %b exp %h %b %b %h %b",
                 i, an, blank_out, dp_out, hex_out, frame_tick,
                 e_an, e_blank, e_dp, e_hex, e_tick);
      end
      if (i >= F && an == 8'hFE) begin
        checks++;
        if (hex_out !== 4'hF) begin
          failures++;
          $display("FAIL wrap_digit0 i=%0d hex=%h exp=F", i, hex_out);
        end
      end
      if (i >= F && an == 8'hFD) begin
        checks++;
        if (hex_out !== 4'hE) begin
          failures++;
          $display("FAIL wrap_digit1 i=%0d hex=%h exp=E", i, hex_out);
        end
      end
    end
  endtask

  task automatic test_lz;
    lz_blank = 1'b1;
    digit_en = 8'hFF;
    for (int i = 0; i < 3 * F; i++) begin
      load = 1'b0;
      if (i == 0) begin
        data_in = 32'h000000A0;
        load    = 1'b1;
      end
      if (i == F) begin
        data_in = 32'h00000000;
        load    = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({an, blank_out, dp_out, hex_out, frame_tick}
          !== {e_an, e_blank, e_dp, e_hex, e_tick}) begin
        failures++;
        $display("FAIL lz_model i=%0d got %h %b %b %h %b exp %h %b %b %h %b",
                 i, an, blank_out, dp_out, hex_out, frame_tick,
                 e_an, e_blank, e_dp, e_hex, e_tick);
      end
      if (i >= F && i < 2 * F) begin
        checks++;
        if ((an | 8'h03) !== 8'hFF) begin
          failures++;
          $display("FAIL lz_high_digits i=%0d an=%h", i, an);
        end
        if ((i % F) / R >= 2) begin
          checks++;
          if (blank_out !== 1'b1) begin
            failures++;
            $display("FAIL lz_blank_flag i=%0d bl=%b exp=1", i, blank_out);
          end
        end
        if (an == 8'hFD) begin
          checks++;
          if (hex_out !== 4'hA) begin
            failures++;
            $display("FAIL lz_digit1 hex=%h exp=A", hex_out);
          end
        end
        if (an == 8'hFE) begin
          checks++;
          if (hex_out !== 4'h0) begin
            failures++;
            $display("FAIL lz_digit0 hex=%h exp=0", hex_out);
          end
        end
      end
      if (i >= 2 * F) begin
        checks++;
        if (an !== 8'hFF && an !== 8'hFE) begin
          failures++;
          $display("FAIL lz_zero_only i=%0d an=%h exp FF or FE", i, an);
        end
        if (an == 8'hFE) begin
          checks++;
          if (hex_out !== 4'h0) begin
            failures++;
            $display("FAIL lz_zero_digit0 hex=%h exp=0", hex_out);
          end
        end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_dp;
    int lit_fb;
    digit_en = 8'h0F;
    lit_fb = 0;
    for (int i = 0; i < 2 * F; i++) begin
      load = 1'b0;
      if (i == 0) begin
        data_in = $urandom;
        dp_in   = 8'h04;
        load    = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({an, blank_out, dp_out, hex_out, frame_tick}
          !== {e_an, e_blank, e_dp, e_hex, e_tick}) begin
        failures++;
        $display("FAIL dp_model i=%0d got %h %b %b %h %b exp %h %b %b %h %b",
                 i, an, blank_out, dp_out, hex_out, frame_tick,
                 e_an, e_blank, e_dp, e_hex, e_tick);
      end
      if (i >= F) begin
        if (an == 8'hFB) lit_fb++;
        checks++;
        if ((dp_out == 1'b0) !== (an == 8'hFB)) begin
          failures++;
          $display("FAIL dp_select i=%0d dp=%b an=%h", i, dp_out, an);
        end
        checks++;
        if (an[7:4] !== 4'hF) begin
          failures++;
          $display("FAIL dp_disabled_anode i=%0d an=%h", i, an);
        end
        if ((i % F) / R >= 4) begin
          checks++;
          if (blank_out !== 1'b1) begin
            failures++;
            $display("FAIL dp_blank i=%0d bl=%b exp=1", i, blank_out);
          end
        end
      end
    end
    checks++;
    if (lit_fb != R - G) begin
      failures++;
      $display("FAIL dp_lit_count got=%0d exp=%0d", lit_fb, R - G);
    end
    digit_en = 8'hFF;
    dp_in    = 8'h00;
  endtask

  task automatic test_random;
    int lit;
    for (int i = 0; i < 1200; i++) begin
      load = ($urandom_range(0, 9) == 0);
      if (load) begin
        data_in = $urandom;
        dp_in   = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 29) == 0) lz_blank = 1'($urandom);
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({an, blank_out, dp_out, hex_out, frame_tick}
          !== {e_an, e_blank, e_dp, e_hex, e_tick}) begin
        failures++;
        $display("FAIL rand_model i=%0d got %h %b %b %h %b exp %h %b %b %h %b",
                 i, an, blank_out, dp_out, hex_out, frame_tick,
                 e_an, e_blank, e_dp, e_hex, e_tick);
      end
      lit = 0;
      for (int b = 0; b < N; b++) begin
        if (!an[b]) lit++;
      end
      checks++;
      if (lit > 1 || (lit == 1) === blank_out) begin
        failures++;
        $display("FAIL rand_onehot i=%0d an=%h bl=%b", i, an, blank_out);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    data_in  = '0;
    dp_in    = '0;
    load     = 1'b0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    test_reset();
    test_scan();
    test_tear();
    test_wrap_load();
    test_lz();
    test_dp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
